// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// datapath select codes and the packed control-word layout.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic             iord;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             reg_write;
        logic             alu_src_a;
        logic             pc_write;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] pc_source;
        logic             instr_done;
        logic             illegal_op;
    } ctrl_t;

    // True for every opcode the controller sequences.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/status inputs and control outputs.
interface multicycle_ctrl_if;
    import mips_ctrl_pkg::*;

    logic [OP_W-1:0]    Opcode;
    logic               Zero;
    logic               MemReady;

    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegDst;
    logic               MemToReg;
    logic               RegWrite;
    logic               ALUSrcA;
    logic               PCWrite;
    logic [SEL_W-1:0]   ALUSrcB;
    logic [SEL_W-1:0]   ALUOp;
    logic [SEL_W-1:0]   PCSource;
    logic               InstrDone;
    logic               IllegalOp;
    logic [STATE_W-1:0] State;

    modport master (
        input  Opcode, Zero, MemReady,
        output IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
               ALUSrcA, PCWrite, ALUSrcB, ALUOp, PCSource, InstrDone,
               IllegalOp, State
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
               ALUSrcA, PCWrite, ALUSrcB, ALUOp, PCSource, InstrDone,
               IllegalOp, State
    );

endinterface

// File: rtl/multicycle_ctrl_dec.sv
// Moore state-to-control decode; only MemReady/Zero/Opcode qualify individual
// bits where the state needs them, and reset forces the whole word to zero.
module multicycle_ctrl_dec
    import mips_ctrl_pkg::*;
(
    input  state_t          state,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        if (!reset) begin
            unique case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH;
                    ctrl.alu_op    = ALUOP_ADD;
                    if (!op_legal(opcode)) begin
                        ctrl.illegal_op = 1'b1;
                        ctrl.instr_done = 1'b1;
                    end
                end
                S_MEMADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    // Store retires on the cycle memory accepts it.
                    ctrl.mem_write  = 1'b1;
                    ctrl.iord       = 1'b1;
                    ctrl.instr_done = mem_ready;
                end
                S_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    ctrl.reg_dst    = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a  = 1'b1;
                    ctrl.alu_src_b  = SRCB_REG;
                    ctrl.alu_op     = ALUOP_SUB;
                    ctrl.pc_source  = PCSRC_ALUOUT;
                    ctrl.pc_write   = zero;
                    ctrl.instr_done = 1'b1;
                end
                S_ADDIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_ADDIWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_JUMP: begin
                    ctrl.pc_source  = PCSRC_JUMP;
                    ctrl.pc_write   = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: state register and sequencing; control
// outputs come from the Moore decode in multicycle_ctrl_dec.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; unused codes fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (bus.Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = bus.MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    multicycle_ctrl_dec u_dec (
        .state     (state_q),
        .reset     (reset),
        .opcode    (bus.Opcode),
        .zero      (bus.Zero),
        .mem_ready (bus.MemReady),
        .ctrl      (ctrl)
    );

    assign bus.IorD      = ctrl.iord;
    assign bus.MemRead   = ctrl.mem_read;
    assign bus.MemWrite  = ctrl.mem_write;
    assign bus.IRWrite   = ctrl.ir_write;
    assign bus.RegDst    = ctrl.reg_dst;
    assign bus.MemToReg  = ctrl.mem_to_reg;
    assign bus.RegWrite  = ctrl.reg_write;
    assign bus.ALUSrcA   = ctrl.alu_src_a;
    assign bus.PCWrite   = ctrl.pc_write;
    assign bus.ALUSrcB   = ctrl.alu_src_b;
    assign bus.ALUOp     = ctrl.alu_op;
    assign bus.PCSource  = ctrl.pc_source;
    assign bus.InstrDone = ctrl.instr_done;
    assign bus.IllegalOp = ctrl.illegal_op;
    assign bus.State     = state_q;

endmodule
